// File: rtl/multi_dataflow_job_sequencer_if.sv
// Handshake bundle between the register file / engine / streamers and the job sequencer.
// The sequencer connects through the slave modport; the driving environment uses master.
interface multi_dataflow_job_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             trigger_i;
  logic [CNT_W-1:0] len_i;
  logic             clear_i;
  logic             eng_ready_i;
  logic [CNT_W-1:0] eng_cnt_i;
  logic             strm_ready_i;
  logic             strm_done_i;
  logic             eng_start_o;
  logic             eng_clear_o;
  logic             strm_start_o;
  logic             busy_o;
  logic             evt_done_o;
  logic             err_o;

  modport slave (
    input  trigger_i, len_i, clear_i, eng_ready_i, eng_cnt_i, strm_ready_i, strm_done_i,
    output eng_start_o, eng_clear_o, strm_start_o, busy_o, evt_done_o, err_o
  );

  modport master (
    output trigger_i, len_i, clear_i, eng_ready_i, eng_cnt_i, strm_ready_i, strm_done_i,
    input  eng_start_o, eng_clear_o, strm_start_o, busy_o, evt_done_o, err_o
  );
endinterface

// File: rtl/multi_dataflow_job_sequencer.sv
// Job sequencer: clears the engine, waits for readiness, starts engine and streamers, and
// signals completion. Optional stall watchdog enabled by MULTI_DATAFLOW_SEQ_WATCHDOG_EN.
module multi_dataflow_job_sequencer #(
  parameter int CNT_W  = 16,
  parameter int WDOG_W = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  multi_dataflow_job_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_RDY,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_len_q;
  logic             r_cnt_hit;
  logic             r_sdone;
  logic             r_abort_clr;
  logic             w_wdog_trip;

`ifdef MULTI_DATAFLOW_SEQ_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  logic [WDOG_W-1:0] r_wdog;
  logic [CNT_W-1:0]  r_prev_cnt;
  logic              r_err;
  logic              w_stalled;

  assign w_stalled   = (r_state == ST_RUN) && (bus.eng_cnt_i == r_prev_cnt);
  // Trip on the stalled cycle that brings the counter to all-ones.
  assign w_wdog_trip = w_stalled && (r_wdog == WDOG_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdog     <= '0;
      r_prev_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_prev_cnt <= bus.eng_cnt_i;
      r_wdog     <= (w_stalled && !bus.clear_i) ? r_wdog + 1'b1 : '0;
      if (bus.clear_i)
        r_err <= 1'b0;
      else if (w_wdog_trip)
        r_err <= 1'b1;
      else if (r_state == ST_IDLE && bus.trigger_i)
        r_err <= 1'b0;
    end
  end

  assign bus.err_o = r_err;
`else
  // Without the watchdog the error flag is permanently low.
  localparam logic [WDOG_W-1:0] WDOG_ABSENT = '0;

  assign w_wdog_trip = 1'b0;
  assign bus.err_o   = |WDOG_ABSENT;
`endif

  // NOTE: every variable gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (bus.trigger_i)
          w_state_next = (bus.len_i != '0) ? ST_CLEAR : ST_DONE;
      ST_CLEAR:    w_state_next = ST_WAIT_RDY;
      ST_WAIT_RDY:
        if (bus.eng_ready_i && bus.strm_ready_i)
          w_state_next = ST_START;
      ST_START:    w_state_next = ST_RUN;
      ST_RUN:
        if ((r_cnt_hit && r_sdone) || w_wdog_trip)
          w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
    if (bus.clear_i)
      w_state_next = ST_IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_len_q     <= '0;
      r_cnt_hit   <= 1'b0;
      r_sdone     <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_abort_clr <= bus.clear_i;
      if (bus.clear_i) begin
        r_cnt_hit <= 1'b0;
        r_sdone   <= 1'b0;
      end else begin
        if (r_state == ST_IDLE || r_state == ST_START) begin
          r_cnt_hit <= 1'b0;
          r_sdone   <= 1'b0;
        end else if (r_state == ST_RUN) begin
          if (bus.eng_cnt_i >= r_len_q)
            r_cnt_hit <= 1'b1;
          if (bus.strm_done_i)
            r_sdone <= 1'b1;
        end
        if (r_state == ST_IDLE && bus.trigger_i && bus.len_i != '0)
          r_len_q <= bus.len_i;
      end
    end
  end

  // Moore outputs: decoded only from registered state and the registered abort flag.
  assign bus.busy_o       = (r_state != ST_IDLE);
  assign bus.eng_clear_o  = (r_state == ST_CLEAR) || r_abort_clr;
  assign bus.eng_start_o  = (r_state == ST_START);
  assign bus.strm_start_o = (r_state == ST_START);
  assign bus.evt_done_o   = (r_state == ST_DONE);

endmodule

// File: tb/tb_multi_dataflow_job_sequencer.sv
// Directed self-checking bench for multi_dataflow_job_sequencer; the watchdog scenario runs
// when MULTI_DATAFLOW_SEQ_WATCHDOG_EN is defined (WDOG_W=4).
module tb_multi_dataflow_job_sequencer;
  localparam int CNT_W = 16;
`ifdef MULTI_DATAFLOW_SEQ_WATCHDOG_EN
  localparam int WDOG_W = 4;
`else
  localparam int WDOG_W = 16;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_evt = 0;
  int   n_clr = 0;
  int   n_start = 0;
  int   e0, c0, s0;

  always #5 clk_i = ~clk_i;

  multi_dataflow_job_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multi_dataflow_job_sequencer #(
    .CNT_W (CNT_W),
    .WDOG_W(WDOG_W)
  ) u_dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk_i) begin
    if (bus.evt_done_o)  n_evt++;
    if (bus.eng_clear_o) n_clr++;
    if (bus.eng_start_o) n_start++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Trigger a job with ready inputs high; returns in the first RUN cycle.
  task automatic start_job(input logic [CNT_W-1:0] len);
    bus.trigger_i = 1'b1;
    bus.len_i     = len;
    step();
    bus.trigger_i = 1'b0;
    bus.len_i     = '0;
    step();
    step();
    step();
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.trigger_i    = 1'b0;
    bus.len_i        = '0;
    bus.clear_i      = 1'b0;
    bus.eng_ready_i  = 1'b0;
    bus.eng_cnt_i    = '0;
    bus.strm_ready_i = 1'b0;
    bus.strm_done_i  = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    check("reset_outputs", {26'd0, bus.eng_start_o, bus.eng_clear_o, bus.strm_start_o,
                            bus.busy_o, bus.evt_done_o, bus.err_o}, 32'd0);

    // Basic job, len=4: clear at N+1, start at N+3, done two cycles after strm_done.
    bus.eng_ready_i  = 1'b1;
    bus.strm_ready_i = 1'b1;
    bus.trigger_i    = 1'b1;
    bus.len_i        = 16'd4;
    step();
    bus.trigger_i = 1'b0;
    check("j1_clear_n1", bus.eng_clear_o, 1);
    check("j1_busy", bus.busy_o, 1);
    step();
    check("j1_wait_no_clear", bus.eng_clear_o, 0);
    check("j1_wait_no_start", bus.eng_start_o, 0);
    step();
    check("j1_start_n3", {bus.eng_start_o, bus.strm_start_o}, 2'b11);
    step();
    check("j1_start_one_cycle", bus.eng_start_o, 0);
    for (int i = 1; i <= 4; i++) begin
      bus.eng_cnt_i = CNT_W'(i);
      step();
    end
    check("j1_no_evt_before_sdone", bus.evt_done_o, 0);
    bus.strm_done_i = 1'b1;
    step();
    bus.strm_done_i = 1'b0;
    check("j1_evt_plus1", bus.evt_done_o, 0);
    step();
    check("j1_evt_plus2", bus.evt_done_o, 1);
    step();
    check("j1_evt_one_cycle", {bus.evt_done_o, bus.busy_o}, 2'b00);

    // Zero-length job goes straight to DONE with no engine pulses.
    bus.eng_cnt_i = '0;
    e0 = n_evt; c0 = n_clr; s0 = n_start;
    bus.trigger_i = 1'b1;
    bus.len_i     = '0;
    step();
    bus.trigger_i = 1'b0;
    check("z_evt", bus.evt_done_o, 1);
    check("z_no_clear", bus.eng_clear_o, 0);
    step();
    check("z_idle", bus.busy_o, 0);
    step();
    check("z_evt_count", n_evt - e0, 1);
    check("z_no_pulses", (n_clr - c0) + (n_start - s0), 0);

    // Engine not ready for 10 cycles, then simultaneous count hit and strm_done.
    bus.eng_ready_i = 1'b0;
    bus.trigger_i   = 1'b1;
    bus.len_i       = 16'd8;
    step();
    bus.trigger_i = 1'b0;
    check("w_clear", bus.eng_clear_o, 1);
    s0 = n_start;
    repeat (10) step();
    check("w_hold_busy", bus.busy_o, 1);
    check("w_hold_no_start", (n_start - s0) + 32'(bus.eng_start_o), 0);
    bus.eng_ready_i = 1'b1;
    step();
    check("w_start_after_ready", bus.eng_start_o, 1);
    step();
    e0 = n_evt;
    bus.eng_cnt_i   = 16'd8;
    bus.strm_done_i = 1'b1;
    step();
    bus.strm_done_i = 1'b0;
    check("sim_evt_early", bus.evt_done_o, 0);
    step();
    check("sim_evt", bus.evt_done_o, 1);
    step();
    check("sim_evt_count", n_evt - e0, 1);

    // strm_done first, count later; retrigger with len=3 mid-RUN must be ignored.
    bus.eng_cnt_i = '0;
    start_job(16'd8);
    e0 = n_evt;
    bus.strm_done_i = 1'b1;
    bus.trigger_i   = 1'b1;
    bus.len_i       = 16'd3;
    step();
    bus.strm_done_i = 1'b0;
    bus.trigger_i   = 1'b0;
    bus.len_i       = '0;
    check("sd_first_no_evt", bus.evt_done_o, 0);
    bus.eng_cnt_i = 16'd5;
    step();
    check("retrig_ignored_a", bus.evt_done_o, 0);
    step();
    check("retrig_ignored_b", {bus.evt_done_o, bus.busy_o}, 2'b01);
    bus.eng_cnt_i = 16'd8;
    step();
    check("cnt_hit_no_evt_yet", bus.evt_done_o, 0);
    step();
    check("sd_first_evt", bus.evt_done_o, 1);
    step();
    check("sd_first_evt_count", n_evt - e0, 1);

    // clear_i mid-RUN (with a competing trigger) aborts with one eng_clear pulse.
    bus.eng_cnt_i = '0;
    start_job(16'd8);
    e0 = n_evt; c0 = n_clr;
    bus.clear_i   = 1'b1;
    bus.trigger_i = 1'b1;
    bus.len_i     = 16'd5;
    step();
    bus.clear_i   = 1'b0;
    bus.trigger_i = 1'b0;
    bus.len_i     = '0;
    check("clr_idle_pulse", {bus.busy_o, bus.eng_clear_o}, 2'b01);
    step();
    check("clr_pulse_one_cycle", {bus.busy_o, bus.eng_clear_o}, 2'b00);
    step();
    check("clr_no_evt", n_evt - e0, 0);
    check("clr_one_clear", n_clr - c0, 1);

    // rst_i mid-RUN with completion conditions present: silent abort.
    start_job(16'd8);
    e0 = n_evt; c0 = n_clr;
    bus.eng_cnt_i   = 16'd8;
    bus.strm_done_i = 1'b1;
    bus.clear_i     = 1'b1;
    rst_i           = 1'b1;
    step();
    rst_i           = 1'b0;
    bus.clear_i     = 1'b0;
    bus.strm_done_i = 1'b0;
    check("rst_outputs", {26'd0, bus.eng_start_o, bus.eng_clear_o, bus.strm_start_o,
                          bus.busy_o, bus.evt_done_o, bus.err_o}, 32'd0);
    step();
    step();
    check("rst_no_pulses", (n_evt - e0) + (n_clr - c0), 0);

`ifdef MULTI_DATAFLOW_SEQ_WATCHDOG_EN
    // Frozen eng_cnt_i: watchdog trips after 15 stalled RUN cycles.
    bus.eng_cnt_i = 16'd3;
    start_job(16'd8);
    e0 = n_evt;
    repeat (14) step();
    check("wd_pre_evt", bus.evt_done_o, 0);
    check("wd_pre_err", bus.err_o, 0);
    step();
    check("wd_evt", bus.evt_done_o, 1);
    check("wd_err", bus.err_o, 1);
    step();
    check("wd_err_sticky", {bus.err_o, bus.busy_o}, 2'b10);
    bus.trigger_i = 1'b1;
    bus.len_i     = '0;
    step();
    bus.trigger_i = 1'b0;
    check("wd_err_cleared", bus.err_o, 0);
    step();
    check("wd_evt_count", n_evt - e0, 2);
`else
    // Stall without the watchdog: RUN must not exit and err_o stays low.
    bus.eng_cnt_i = 16'd3;
    start_job(16'd8);
    repeat (20) step();
    check("nowd_still_busy", {bus.busy_o, bus.err_o}, 2'b10);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    check("nowd_cleared", bus.busy_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_dataflow_job_sequencer.md
MULTI_DATAFLOW_JOB_SEQUENCER -- requirements
Module: multi_dataflow_job_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of job length and engine output-beat count.
REQ-002 SHALL have parameter WDOG_W, default 16, width of the stall watchdog counter.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port trigger_i, input, 1, job-start pulse from the register file.
REQ-006 SHALL have port len_i, input, CNT_W, expected output beats for the job; sampled with trigger_i.
REQ-007 SHALL have port clear_i, input, 1, soft clear/abort.
REQ-008 SHALL have port eng_ready_i, input, 1, engine ready flag.
REQ-009 SHALL have port eng_cnt_i, input, CNT_W, engine output-beat counter.
REQ-010 SHALL have port strm_ready_i, input, 1, streamers ready.
REQ-011 SHALL have port strm_done_i, input, 1, output-streamer done pulse.
REQ-012 SHALL have port eng_start_o, output, 1, engine start pulse.
REQ-013 SHALL have port eng_clear_o, output, 1, engine clear pulse.
REQ-014 SHALL have port strm_start_o, output, 1, streamer start pulse.
REQ-015 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-016 SHALL have port evt_done_o, output, 1, job-complete event pulse.
REQ-017 SHALL have port err_o, output, 1, sticky watchdog error.

Function
REQ-018 SHALL implement Moore FSM IDLE, CLEAR, WAIT_RDY, START, RUN, DONE; all outputs decoded from registered state/flags, no input-to-output combinational path.
REQ-019 IDLE: trigger_i=1 and len_i!=0 -> latch len_i into len_q, go CLEAR; trigger_i=1 and len_i==0 -> go DONE directly, no engine pulses.
REQ-020 CLEAR: eng_clear_o=1 for exactly one cycle; go WAIT_RDY.
REQ-021 WAIT_RDY: stay until eng_ready_i=1 and strm_ready_i=1 in the same cycle; then go START.
REQ-022 START: eng_start_o=1 and strm_start_o=1 for exactly one cycle, simultaneous; clear sticky flags; go RUN.
REQ-023 RUN: sticky cnt_hit set when eng_cnt_i >= len_q (unsigned CNT_W compare); sticky sdone set when strm_done_i=1; go DONE in the cycle after both are set, in either order or simultaneously.
REQ-024 DONE: evt_done_o=1 for exactly one cycle; go IDLE.
REQ-025 Latency: trigger_i sampled at edge N -> eng_clear_o high in cycle N+1; with ready inputs already high, start pulses in cycle N+3.
REQ-026 trigger_i while busy_o=1 SHALL be ignored; len_q SHALL not change.
REQ-027 clear_i=1 in any state SHALL force IDLE at the next edge, assert eng_clear_o for one cycle, clear sticky flags and err_o, suppress evt_done_o; clear_i has priority over trigger_i.
REQ-028 eng_cnt_i wrap-around SHALL not be tracked; once set, cnt_hit stays set until START, IDLE or clear.

Reset
REQ-029 rst_i=1 at a rising edge SHALL force IDLE, len_q=0, sticky flags=0, watchdog=0, err_o=0; all outputs 0 in the following cycle.
REQ-030 rst_i mid-job SHALL abort without eng_clear_o or evt_done_o; rst_i has priority over clear_i and trigger_i.

Configuration
REQ-031 Macro MULTI_DATAFLOW_SEQ_WATCHDOG_EN defined: WDOG_W counter increments each RUN cycle in which eng_cnt_i is unchanged from the previous cycle, resets to 0 on any change or on leaving RUN; on reaching all-ones -> err_o=1 (sticky until next accepted trigger_i, clear_i or reset), FSM goes DONE (evt_done_o pulses).
REQ-032 Macro undefined: no watchdog counter; err_o constant 0; RUN exits only per REQ-023.

Verification
REQ-033 Reset then trigger_i, len_i=4, ready inputs high, eng_cnt_i 0..4, strm_done_i after cnt=4 -> clear at N+1, start at N+3, one evt_done_o two cycles after strm_done_i.
REQ-034 trigger_i, len_i=0 -> evt_done_o one cycle later, eng_clear_o/eng_start_o never asserted.
REQ-035 eng_ready_i low 10 cycles after CLEAR -> FSM holds WAIT_RDY, start pulses exactly one cycle after ready goes high.
REQ-036 strm_done_i before eng_cnt_i reaches len=8, and separately the same cycle -> single evt_done_o after both conditions; second trigger_i mid-RUN ignored.
REQ-037 clear_i mid-RUN -> IDLE next cycle, one eng_clear_o, no evt_done_o; rst_i mid-RUN -> all outputs 0, no pulses.
REQ-038 With MULTI_DATAFLOW_SEQ_WATCHDOG_EN, WDOG_W=4, eng_cnt_i frozen in RUN -> err_o=1 and evt_done_o after 15 stalled cycles; err_o cleared by next trigger_i.
